// File: rtl/tile_pkg.sv
// tile_pkg -- shared definitions for the tile cache-line request/response path.
//
// Holds the write-request field layout (address split, size word), the response
// packet layout, the responder FSM state encoding, the response-queue geometry
// and a helper that assembles a response packet from its fields.
package tile_pkg;

   // Request-side (wrreq) field definitions
   localparam int DATA_W      = 528;
   localparam int COORD_W     = 5;
   localparam int OFF_W       = 27;
   localparam int ADDR_W      = OFF_W + 2 * COORD_W;   // {TY, TX, offset}
   localparam int ADDR_TX_LSB = OFF_W;
   localparam int ADDR_TY_LSB = OFF_W + COORD_W;
   localparam int SRC_W       = 2 * COORD_W;           // {TY, TX}
   localparam int SIZE_W      = 12;
   localparam int SIZE_WR_BIT = 9;                     // 1 = write, 0 = read

   // Response packet layout
   localparam int RSP_W         = 584;
   localparam int RSP_SND_BIT   = 0;
   localparam int RSP_DATA_LSB  = 1;
   localparam int RSP_TX_LSB    = 529;
   localparam int RSP_TY_LSB    = 534;
   localparam int RSP_OFF_LSB   = 539;
   localparam int RSP_SIZE_LSB  = 566;
   localparam int RSP_WRACK_BIT = 578;
   localparam int RSP_SPARE_LSB = 579;
   localparam int RSP_SPARE_W   = RSP_W - RSP_SPARE_LSB;

   // Response queue geometry
   localparam int RSPQ_DEPTH = 4;
   localparam int RSPQ_PTR_W = 2;
   localparam int RSPQ_CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_SEND  = 2'd3
   } cl_state_t;

   // Values 0/1 double as the rsp_out link index.
   typedef enum logic [1:0] {
      RT_BACK  = 2'd0,
      RT_FWD   = 2'd1,
      RT_LOCAL = 2'd2
   } rsp_route_t;

   // Packet as stored in the queue: snd is set, spare bits are zero.
   function automatic logic [RSP_W-1:0] rsp_pack(
      input logic [SRC_W-1:0]  dest,
      input logic [OFF_W-1:0]  off,
      input logic [SIZE_W-1:0] size,
      input logic [DATA_W-1:0] data,
      input logic              wr_ack
   );
      rsp_pack = {{RSP_SPARE_W{1'b0}}, wr_ack, size, off, dest, data, 1'b1};
   endfunction

endpackage

// File: rtl/tile_rsp_queue.sv
// tile_rsp_queue -- 4-entry in-order response queue.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointers and count only)
//   push       : write push_data at the tail (caller guarantees a free slot)
//   push_data  : packet to enqueue
//   pop        : retire the head entry (ignored when empty)
//   head       : packet at the head, valid while count != 0
//   count      : number of occupied entries (0..4)
module tile_rsp_queue
   import tile_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [RSP_W-1:0]      push_data,
   input  logic                  pop,
   output logic [RSP_W-1:0]      head,
   output logic [RSPQ_CNT_W-1:0] count
);

   logic [RSP_W-1:0]      entry_mem [RSPQ_DEPTH];
   logic [RSPQ_PTR_W-1:0] wr_ptr_reg;
   logic [RSPQ_PTR_W-1:0] rd_ptr_reg;
   logic [RSPQ_CNT_W-1:0] count_reg;
   logic                  pop_ok;

   assign pop_ok = pop && (count_reg != '0);

   // 2-bit pointers wrap 3 -> 0 by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + RSPQ_PTR_W'(1);
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + RSPQ_PTR_W'(1);
         if (push && !pop_ok)
            count_reg <= count_reg + RSPQ_CNT_W'(1);
         else if (!push && pop_ok)
            count_reg <= count_reg - RSPQ_CNT_W'(1);
      end
   end

   // Payload storage is not reset; stale entries are never visible once the
   // count is cleared.
   always_ff @(posedge clk) begin
      if (push)
         entry_mem[wr_ptr_reg] <= push_data;
   end

   // Head must be visible in the cycle it is routed, so the read is direct.
   assign head  = entry_mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/tile_cl_resp.sv
// tile_cl_resp -- tile cache-line responder.
//
// Accepts one request at a time from the tile request FIFO, performs the
// memory access, and queues a response packet routed back to the originator
// along one mesh dimension (X when IDX<2, Y otherwise).
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake (req_ready is the FIFO outen)
//   req_data/addr/size/src   : request payload
//   mem_req/we/addr/wdata    : memory request, held until mem_gnt
//   mem_gnt                  : memory accepted the request
//   mem_rvalid/mem_rdata     : read return (taken only while waiting for it)
//   rsp_out[0]=back, [1]=fwd : response links; bit 0 (snd) marks a packet
//   rsp_stall[1:0]           : per-link downstream full
//   rsp_local/rsp_local_en   : response for this tile
module tile_cl_resp
   import tile_pkg::*;
#(
   parameter int tile_X = 0,
   parameter int tile_Y = 0,
   parameter int IDX    = 0
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_W-1:0]     req_data,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [SIZE_W-1:0]     req_size,
   input  logic [SRC_W-1:0]      req_src,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [OFF_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic [1:0][RSP_W-1:0] rsp_out,
   input  logic [1:0]            rsp_stall,
   output logic [RSP_W-1:0]      rsp_local,
   output logic                  rsp_local_en
);

   localparam logic [COORD_W-1:0] TILE_COORD =
      (IDX < 2) ? COORD_W'(tile_X) : COORD_W'(tile_Y);
   localparam int DEST_LSB = (IDX < 2) ? RSP_TX_LSB : RSP_TY_LSB;

   cl_state_t             state_reg;
   logic                  mem_req_reg;
   logic [DATA_W-1:0]     wdata_reg;
   logic [DATA_W-1:0]     rdata_reg;
   logic [OFF_W-1:0]      off_reg;
   logic [SIZE_W-1:0]     size_reg;
   logic [SRC_W-1:0]      src_reg;
   logic                  we;
   logic                  admit;

   logic                  push;
   logic                  pop;
   logic [RSP_W-1:0]      push_pkt;
   logic [RSP_W-1:0]      head_pkt;
   logic [RSPQ_CNT_W-1:0] rspq_count;
   logic                  head_valid;
   logic [COORD_W-1:0]    head_coord;
   rsp_route_t            route;
   logic                  unused_addr;

   // The request's own tile coordinates are implied by delivery to this tile.
   assign unused_addr = ^req_addr[ADDR_W-1:ADDR_TX_LSB];

   assign we = size_reg[SIZE_WR_BIT];

   // Only one request is in flight and it has already pushed its response by
   // the time the FSM is back in IDLE, so count<4 reserves the slot it needs.
   assign admit     = !rst && (state_reg == ST_IDLE) && req_valid &&
                      (rspq_count < RSPQ_CNT_W'(RSPQ_DEPTH));
   assign req_ready = admit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         mem_req_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (admit) begin
                  state_reg   <= ST_ISSUE;
                  mem_req_reg <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (mem_gnt) begin
                  mem_req_reg <= 1'b0;
                  state_reg   <= we ? ST_SEND : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid)
                  state_reg <= ST_SEND;
            end
            ST_SEND: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Payload registers carry no reset.
   always_ff @(posedge clk) begin
      if (admit) begin
         wdata_reg <= req_data;
         off_reg   <= req_addr[OFF_W-1:0];
         size_reg  <= req_size;
         src_reg   <= req_src;
      end
      if ((state_reg == ST_WAIT) && mem_rvalid)
         rdata_reg <= mem_rdata;
   end

   assign mem_req   = mem_req_reg;
   assign mem_we    = mem_req_reg && we;
   assign mem_addr  = off_reg;
   assign mem_wdata = wdata_reg;

   assign push     = (state_reg == ST_SEND);
   assign push_pkt = rsp_pack(src_reg, off_reg, size_reg,
                              we ? '0 : rdata_reg, we);

   tile_rsp_queue u_rsp_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_pkt),
      .pop       (pop),
      .head      (head_pkt),
      .count     (rspq_count)
   );

   assign head_valid = (rspq_count != '0);
   assign head_coord = head_pkt[DEST_LSB +: COORD_W];

   always_comb begin
      route = RT_LOCAL;
      if (head_coord > TILE_COORD)
         route = RT_FWD;
      else if (head_coord < TILE_COORD)
         route = RT_BACK;
   end

   // A stalled head holds the whole queue; local delivery never stalls.
   assign pop = !rst && head_valid &&
                ((route == RT_LOCAL) || !rsp_stall[route[0]]);

   // Every output shows the head payload; only the popped target gets snd.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_link
         localparam logic [1:0] LINK_ROUTE = 2'(gi);
         assign rsp_out[gi] = {head_pkt[RSP_W-1:1],
                               pop && (route == rsp_route_t'(LINK_ROUTE))};
      end
   endgenerate

   assign rsp_local_en = pop && (route == RT_LOCAL);
   assign rsp_local    = {head_pkt[RSP_W-1:1], rsp_local_en};

endmodule
